dmem_responder: RTL and testbench

Responder side of the miniRV data-memory interface: accepts load/store requests issued by the CPU core (address, write data, byte strobes), services them against an internal word-addressed RAM with a configurable number of wait states, and returns read data plus an error flag through a valid/ready response channel. It replaces the combinational data-memory model inside the core, so `lw`/`lbu`/`sw`/`sb` traffic becomes a real request/response transaction with backpressure.

---
 rtl/miniRV_pkg.sv | 26 ++
 rtl/dmem_array.sv | 32 +++
 rtl/dmem_responder.sv | 114 +++++++++++
 tb/tb_dmem_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/miniRV_pkg.sv
// Shared types and helpers for the miniRV data-memory responder.
package miniRV_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } dmem_state_t;

    localparam logic [3:0] WSTRB_READ = 4'b0000;
    localparam logic [3:0] WSTRB_WORD = 4'b1111;

    // addr is the byte offset within the word; only full-word stores care about it.
    function automatic logic wstrb_legal(input logic [1:0] addr, input logic [3:0] wstrb);
        logic onehot;
        onehot = (wstrb != 4'b0000) && ((wstrb & (wstrb - 4'd1)) == 4'b0000);
        if (wstrb == WSTRB_READ) begin
            return 1'b1;
        end
        if (wstrb == WSTRB_WORD) begin
            return addr == 2'b00;
        end
        return onehot;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed RAM with per-byte write enables; merged word is visible combinationally
// so the caller can capture the post-write value on the same edge that commits it.
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    output logic [31:0]      rmw_word
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_comb begin
        rmw_word = mem_q[idx];
        for (int k = 0; k < 4; k++) begin
            if (wstrb[k]) begin
                rmw_word[8*k +: 8] = wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= rmw_word;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: request/response handshake around dmem_array with LATENCY cycles
// between acceptance and resp_valid, plus address/strobe error screening.
module dmem_responder
    import miniRV_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        err_now;
    logic        commit;
    logic [31:0] rmw_word;

    assign err_now = ({2'b00, addr_q[31:2]} >= DEPTH_WORDS) || !wstrb_legal(addr_q[1:0], wstrb_q);
    assign commit  = (state_q == BUSY) && (cnt_q == 4'd0);

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk      (clk),
        .we       (commit && !err_now),
        .idx      (addr_q[IDX_W+1:2]),
        .wdata    (wdata_q),
        .wstrb    (wstrb_q),
        .rmw_word (rmw_word)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = (state_q == IDLE) && !reset;
        resp_valid = (state_q == RESP);

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            // BUSY always lasts cnt+1 cycles, so RESP is entered LATENCY edges after acceptance.
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    rdata_d = err_now ? 32'h0 : rmw_word;
                    err_d   = err_now;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: three responders (LATENCY 1, 3, 4) exercised one at a time.
module tb_dmem_responder;

    localparam int N = 3;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
    endfunction

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid  [N];
    logic        req_ready  [N];
    logic [31:0] req_addr   [N];
    logic [31:0] req_wdata  [N];
    logic [3:0]  req_wstrb  [N];
    logic        resp_valid [N];
    logic        resp_ready [N];
    logic [31:0] resp_rdata [N];
    logic        resp_err   [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_WORDS (1024),
            .LATENCY     ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .req_wstrb  (req_wstrb[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g])
        );
    end

    typedef struct {
        int          inst;
        logic [31:0] rdata;
        logic        err;
        int          accept;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one request; the expected response is queued at the accepting edge.
    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit exp_resp, input logic [31:0] er,
                         input logic e, output int acc);
        int waited;
        bit done;
        waited = 0;
        done   = 0;
        acc    = -1;
        req_addr[i]  = a;
        req_wdata[i] = d;
        req_wstrb[i] = s;
        req_valid[i] = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (req_ready[i] === 1'b1) begin
                done = 1;
                acc  = cyc + 1;
                if (exp_resp) exp_q.push_back('{i, er, e, acc, lat_of(i)});
            end else if (++waited > 40) begin
                done = 1;
                check($sformatf("inst%0d accept_timeout addr 0x%08h", i, a), 32'd0, 32'd1);
            end
        end
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    // Monitor: pops an expectation when a response appears, then checks it stays stable.
    logic        prev_valid [N];
    logic [31:0] held_rdata [N];
    logic        held_err   [N];
    bit          chk_ready  [N];

    initial begin
        for (int i = 0; i < N; i++) begin
            prev_valid[i] = 1'b0;
            chk_ready[i]  = 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (chk_ready[i]) begin
                chk_ready[i] = 1'b0;
                check($sformatf("inst%0d req_ready_after_hs", i), 32'(req_ready[i]), 32'd1);
                check($sformatf("inst%0d valid_drop_after_hs", i), 32'(resp_valid[i]), 32'd0);
            end
            if (resp_valid[i] === 1'b1) begin
                if (!prev_valid[i]) begin
                    if (exp_q.size() == 0 || exp_q[0].inst != i) begin
                        check($sformatf("inst%0d unexpected_response", i), 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check($sformatf("inst%0d rdata", i), resp_rdata[i], e.rdata);
                        check($sformatf("inst%0d err", i), 32'(resp_err[i]), 32'(e.err));
                        check($sformatf("inst%0d latency", i), 32'(cyc - e.accept), 32'(e.lat));
                    end
                    held_rdata[i] = resp_rdata[i];
                    held_err[i]   = resp_err[i];
                end else begin
                    check($sformatf("inst%0d stall_rdata", i), resp_rdata[i], held_rdata[i]);
                    check($sformatf("inst%0d stall_err", i), 32'(resp_err[i]), 32'(held_err[i]));
                end
                check($sformatf("inst%0d req_ready_in_resp", i), 32'(req_ready[i]), 32'd0);
                if (resp_ready[i] === 1'b1) chk_ready[i] = 1'b1;
            end
            prev_valid[i] = (resp_valid[i] === 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1;
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_valid[i]  = 1'b0;
            req_addr[i]   = 32'h0;
            req_wdata[i]  = 32'h0;
            req_wstrb[i]  = 4'h0;
            resp_ready[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset req_ready", 32'(req_ready[0]), 32'd0);
        check("reset resp_valid", 32'(resp_valid[0]), 32'd0);
        check("reset resp_rdata", resp_rdata[0], 32'h0);
        check("reset resp_err", 32'(resp_err[0]), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset req_ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk);
        #1;

        // LATENCY=1: word write, read, byte merge.
        issue(0, 32'h10, 32'hDEADBEEF, 4'b1111, 1, 32'hDEADBEEF, 1'b0, a0);
        issue(0, 32'h10, 32'h0, 4'b0000, 1, 32'hDEADBEEF, 1'b0, a0);
        issue(0, 32'h12, 32'h00AA0000, 4'b0100, 1, 32'hDEAABEEF, 1'b0, a0);
        issue(0, 32'h10, 32'h0, 4'b0000, 1, 32'hDEAABEEF, 1'b0, a0);

        // Error cases must leave RAM (including aliased words) untouched.
        issue(0, 32'h0, 32'hCAFEF00D, 4'b1111, 1, 32'hCAFEF00D, 1'b0, a0);
        issue(0, 32'h4, 32'h01020304, 4'b1111, 1, 32'h01020304, 1'b0, a0);
        issue(0, 32'h1000, 32'hFFFFFFFF, 4'b1111, 1, 32'h0, 1'b1, a0);
        issue(0, 32'h6, 32'hFFFFFFFF, 4'b1111, 1, 32'h0, 1'b1, a0);
        issue(0, 32'h10, 32'hFFFFFFFF, 4'b0011, 1, 32'h0, 1'b1, a0);
        issue(0, 32'h0, 32'h0, 4'b0000, 1, 32'hCAFEF00D, 1'b0, a0);
        issue(0, 32'h4, 32'h0, 4'b0000, 1, 32'h01020304, 1'b0, a0);
        issue(0, 32'h10, 32'h0, 4'b0000, 1, 32'hDEAABEEF, 1'b0, a0);

        // LATENCY=3 with a stalled response channel.
        resp_ready[1] = 1'b0;
        issue(1, 32'h8, 32'h55AA55AA, 4'b1111, 1, 32'h55AA55AA, 1'b0, a0);
        wait_cycles(8);
        resp_ready[1] = 1'b1;
        issue(1, 32'h8, 32'h0, 4'b0000, 1, 32'h55AA55AA, 1'b0, a0);

        // Back-to-back write then read: next acceptance LATENCY+2 cycles later.
        issue(1, 32'h40, 32'h11111111, 4'b1111, 1, 32'h11111111, 1'b0, a0);
        issue(1, 32'h40, 32'h0, 4'b0000, 1, 32'h11111111, 1'b0, a1);
        check("b2b accept_gap", 32'(a1 - a0), 32'd5);
        wait_cycles(8);

        // LATENCY=4: reset while BUSY discards the write.
        issue(2, 32'h20, 32'hA5A5A5A5, 4'b1111, 1, 32'hA5A5A5A5, 1'b0, a0);
        issue(2, 32'h20, 32'h12345678, 4'b1111, 0, 32'h0, 1'b0, a0);
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset req_ready", 32'(req_ready[2]), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_cycles(6);
        issue(2, 32'h20, 32'h0, 4'b0000, 1, 32'hA5A5A5A5, 1'b0, a0);

        wait_cycles(10);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
